truth_table_checker: RTL and testbench

Synthesizable, parametrised successor to the simulation-only exhaustive truth-table sweep used for lab combinational blocks. On a start pulse it drives every input vector from 0 to 2^IN_W−1 into a combinational unit under test. It compares the unit's outputs against a golden-model output bus and counts per-bit mismatches. It also captures the first failing vector and reports completion. It sits on the FPGA beside the unit under test and its golden model, so a board-level self-test can run from a button press with results shown on LEDs or seven-segment displays.

---
 rtl/truth_table_pkg.sv | 30 +++
 rtl/mismatch_accum.sv | 72 +++++++
 rtl/truth_table_checker.sv | 115 +++++++++++
 tb/tb_truth_table_checker.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// Shared types and helpers for the exhaustive truth-table checker.
// Holds the FSM state encoding, counter-width helper and output popcount.
package truth_table_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } tt_state_t;

    // Widest compared output bus and the width needed to count its bits (0..32).
    localparam int unsigned MAX_OUT_W = 32;
    localparam int unsigned POP_W     = 6;

    // Bits needed to hold values 0..max_val; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [MAX_OUT_W-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAX_OUT_W; i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/mismatch_accum.sv
// Accumulates mismatched output bits (saturating) and captures the first
// failing vector together with its mismatch mask.
module mismatch_accum
    import truth_table_pkg::*;
#(
    parameter int unsigned IN_W  = 3,
    parameter int unsigned OUT_W = 4,
    parameter int unsigned ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [OUT_W-1:0] mask_i,
    input  logic [IN_W-1:0]  vec_i,
    output logic [ERR_W-1:0] err_count_o,
    output logic             fail_valid_o,
    output logic [IN_W-1:0]  fail_vec_o,
    output logic [OUT_W-1:0] fail_mask_o
);

    localparam int unsigned SUM_W = ERR_W + POP_W;
    localparam logic [SUM_W-1:0] ERR_MAX = SUM_W'({ERR_W{1'b1}});

    logic [ERR_W-1:0] err_count_q, err_count_d;
    logic             fail_valid_q, fail_valid_d;
    logic [IN_W-1:0]  fail_vec_q, fail_vec_d;
    logic [OUT_W-1:0] fail_mask_q, fail_mask_d;
    logic [SUM_W-1:0] sum;

    always_comb begin
        // Widened add so one vector's worth of mismatches can never wrap before saturation.
        sum          = SUM_W'(err_count_q) + SUM_W'(popcount(MAX_OUT_W'(mask_i)));
        err_count_d  = err_count_q;
        fail_valid_d = fail_valid_q;
        fail_vec_d   = fail_vec_q;
        fail_mask_d  = fail_mask_q;
        if (clr_i) begin
            err_count_d  = '0;
            fail_valid_d = 1'b0;
            fail_vec_d   = '0;
            fail_mask_d  = '0;
        end else if (en_i) begin
            err_count_d = (sum > ERR_MAX) ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
            if ((mask_i != '0) && !fail_valid_q) begin
                fail_valid_d = 1'b1;
                fail_vec_d   = vec_i;
                fail_mask_d  = mask_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_q  <= '0;
            fail_valid_q <= 1'b0;
            fail_vec_q   <= '0;
            fail_mask_q  <= '0;
        end else begin
            err_count_q  <= err_count_d;
            fail_valid_q <= fail_valid_d;
            fail_vec_q   <= fail_vec_d;
            fail_mask_q  <= fail_mask_d;
        end
    end

    assign err_count_o  = err_count_q;
    assign fail_valid_o = fail_valid_q;
    assign fail_vec_o   = fail_vec_q;
    assign fail_mask_o  = fail_mask_q;

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps every input vector of a combinational unit, holding each for SETTLE
// cycles, and compares its outputs against a golden model on the next cycle.
module truth_table_checker #(
    parameter int unsigned IN_W   = 3,
    parameter int unsigned OUT_W  = 4,
    parameter int unsigned SETTLE = 1,
    parameter int unsigned ERR_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [IN_W-1:0]            vec,
    input  logic [OUT_W-1:0]           dut_out,
    input  logic [OUT_W-1:0]           exp_out,
    output logic                       busy,
    output logic                       done,
    output logic [ERR_W-1:0]           err_count,
    output logic                       fail_valid,
    output logic [IN_W-1:0]            fail_vec,
    output logic [OUT_W-1:0]           fail_mask,
    output truth_table_pkg::tt_state_t dbg_state
);

    import truth_table_pkg::*;

    localparam int unsigned CNT_W = cnt_width(SETTLE);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [IN_W-1:0]  LAST_VEC    = {IN_W{1'b1}};

    tt_state_t        state_q, state_d;
    logic [IN_W-1:0]  vec_q, vec_d;
    logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             accum_clr;
    logic             accum_en;

    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        settle_cnt_d = settle_cnt_q;
        accum_clr    = 1'b0;
        accum_en     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = truth_table_pkg::SETTLE;
                    vec_d        = '0;
                    settle_cnt_d = '0;
                    accum_clr    = 1'b1;
                end
            end
            truth_table_pkg::SETTLE: begin
                if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end else begin
                    settle_cnt_d = settle_cnt_q + CNT_W'(1);
                end
            end
            CHECK: begin
                accum_en = 1'b1;
                // The last vector parks in DONE; vec never wraps back to zero.
                if (vec_q == LAST_VEC) begin
                    state_d = DONE;
                end else begin
                    vec_d        = vec_q + IN_W'(1);
                    settle_cnt_d = '0;
                    state_d      = truth_table_pkg::SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == truth_table_pkg::SETTLE) || (state_d == CHECK);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            vec_q        <= '0;
            settle_cnt_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            settle_cnt_q <= settle_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    mismatch_accum #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .ERR_W (ERR_W)
    ) u_accum (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (accum_clr),
        .en_i         (accum_en),
        .mask_i       (dut_out ^ exp_out),
        .vec_i        (vec_q),
        .err_count_o  (err_count),
        .fail_valid_o (fail_valid),
        .fail_vec_o   (fail_vec),
        .fail_mask_o  (fail_mask)
    );

    assign vec       = vec_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: three configured instances share one clock;
// a behavioural model predicts per-cycle vec/busy/done and the running results.
module tb_truth_table_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start;
    int   sel;
    logic [3:0] flip [16];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic start_a, start_b, start_c;
    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    // Instance A: defaults. B: ERR_W=4. C: IN_W=4, SETTLE=3.
    logic [2:0] vec_a, fvec_a, vec_b, fvec_b;
    logic [3:0] vec_c, fvec_c;
    logic [3:0] dut_a, exp_a, dut_b, exp_b, dut_c, exp_c;
    logic [3:0] fmask_a, fmask_b, fmask_c;
    logic [7:0] err_a, err_c;
    logic [3:0] err_b;
    logic busy_a, busy_b, busy_c, done_a, done_b, done_c, fv_a, fv_b, fv_c;
    truth_table_pkg::tt_state_t st_a, st_b, st_c;

    function automatic logic [3:0] gold(input logic [2:0] v);
        logic a, b, c;
        logic [3:0] o;
        a = v[2];
        b = v[1];
        c = v[0];
        o[0] = (a & c) | (~a & b);
        o[1] = (a | ~c) & b & c;
        o[2] = (a & ~b) | c;
        o[3] = ~(~(a & b) & (~c & ~b));
        return o;
    endfunction

    always_comb begin
        exp_a = gold(vec_a);
        dut_a = exp_a ^ flip[vec_a];
        exp_b = gold(vec_b);
        dut_b = exp_b ^ flip[vec_b];
        exp_c = gold(vec_c[2:0]);
        dut_c = exp_c ^ flip[vec_c];
    end

    truth_table_checker #(.IN_W(3), .OUT_W(4), .SETTLE(1), .ERR_W(8)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .vec(vec_a), .dut_out(dut_a), .exp_out(exp_a),
        .busy(busy_a), .done(done_a), .err_count(err_a), .fail_valid(fv_a),
        .fail_vec(fvec_a), .fail_mask(fmask_a), .dbg_state(st_a));

    truth_table_checker #(.IN_W(3), .OUT_W(4), .SETTLE(1), .ERR_W(4)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .vec(vec_b), .dut_out(dut_b), .exp_out(exp_b),
        .busy(busy_b), .done(done_b), .err_count(err_b), .fail_valid(fv_b),
        .fail_vec(fvec_b), .fail_mask(fmask_b), .dbg_state(st_b));

    truth_table_checker #(.IN_W(4), .OUT_W(4), .SETTLE(3), .ERR_W(8)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .vec(vec_c), .dut_out(dut_c), .exp_out(exp_c),
        .busy(busy_c), .done(done_c), .err_count(err_c), .fail_valid(fv_c),
        .fail_vec(fvec_c), .fail_mask(fmask_c), .dbg_state(st_c));

    logic [3:0] o_vec, o_fvec, o_fmask;
    logic [7:0] o_err;
    logic       o_busy, o_done, o_fv;
    truth_table_pkg::tt_state_t o_state;

    always_comb begin
        o_vec = {1'b0, vec_a}; o_fvec = {1'b0, fvec_a}; o_fmask = fmask_a; o_err = err_a;
        o_busy = busy_a; o_done = done_a; o_fv = fv_a; o_state = st_a;
        if (sel == 1) begin
            o_vec = {1'b0, vec_b}; o_fvec = {1'b0, fvec_b}; o_fmask = fmask_b; o_err = {4'b0, err_b};
            o_busy = busy_b; o_done = done_b; o_fv = fv_b; o_state = st_b;
        end else if (sel == 2) begin
            o_vec = vec_c; o_fvec = fvec_c; o_fmask = fmask_c; o_err = err_c;
            o_busy = busy_c; o_done = done_c; o_fv = fv_c; o_state = st_c;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    // Expected error count after the first k vectors have been checked.
    function automatic int model_err(input int k, input int emax);
        int s;
        s = 0;
        for (int v = 0; v < k; v++) s += $countones(flip[v]);
        return (s > emax) ? emax : s;
    endfunction

    // Index of the first faulty vector among the first k, or -1 if none.
    function automatic int model_first(input int k);
        for (int v = 0; v < k; v++) if (flip[v] != 4'h0) return v;
        return -1;
    endfunction

    task automatic sweep(input string tag, input int pulse_t);
        int s, n, emax, last_t, ff;
        s      = (sel == 2) ? 3 : 1;
        n      = (sel == 2) ? 16 : 8;
        emax   = (sel == 1) ? 15 : 255;
        last_t = n * (s + 1);
        @(negedge clk);
        start = 1'b1;
        for (int t = 0; t <= last_t; t++) begin
            @(negedge clk);
            start = (t == pulse_t || t == pulse_t + 1) ? 1'b1 : 1'b0;
            if (t < last_t) begin
                check($sformatf("%s.busy@%0d", tag, t), 32'(o_busy), 32'd1);
                check($sformatf("%s.done@%0d", tag, t), 32'(o_done), 32'd0);
                check($sformatf("%s.vec@%0d", tag, t), 32'(o_vec), 32'(t / (s + 1)));
            end else begin
                check($sformatf("%s.busy_end", tag), 32'(o_busy), 32'd0);
                check($sformatf("%s.done_end", tag), 32'(o_done), 32'd1);
                check($sformatf("%s.vec_end", tag), 32'(o_vec), 32'(n - 1));
            end
            if (t % (s + 1) == 0) begin
                check($sformatf("%s.err@%0d", tag, t), 32'(o_err), 32'(model_err(t / (s + 1), emax)));
                check($sformatf("%s.fv@%0d", tag, t), 32'(o_fv), 32'(model_first(t / (s + 1)) >= 0));
            end
        end
        start = 1'b0;
        ff = model_first(n);
        check({tag, ".fail_vec"}, 32'(o_fvec), (ff >= 0) ? 32'(ff) : 32'd0);
        check({tag, ".fail_mask"}, 32'(o_fmask), (ff >= 0) ? 32'(flip[ff]) : 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".state"}, 32'(o_state), 32'(truth_table_pkg::IDLE));
        check({tag, ".vec"}, 32'(o_vec), 32'd0);
        check({tag, ".busy"}, 32'(o_busy), 32'd0);
        check({tag, ".done"}, 32'(o_done), 32'd0);
        check({tag, ".err"}, 32'(o_err), 32'd0);
        check({tag, ".fv"}, 32'(o_fv), 32'd0);
        check({tag, ".fvec"}, 32'(o_fvec), 32'd0);
        check({tag, ".fmask"}, 32'(o_fmask), 32'd0);
    endtask

    task automatic reset_mid_sweep();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_mid.vec_before", 32'(o_vec), 32'd5);
        check("rst_mid.busy_before", 32'(o_busy), 32'd1);
        check("rst_mid.err_before", 32'(o_err), 32'(model_err(5, 255)));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("rst_mid");
    endtask

    task automatic set_flips_random();
        for (int v = 0; v < 16; v++)
            flip[v] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        sel   = 0;
        for (int v = 0; v < 16; v++) flip[v] = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset_a");
        sel = 1;
        check_reset_outputs("reset_b");
        sel = 2;
        check_reset_outputs("reset_c");

        sel = 0;
        sweep("clean", -1);

        for (int v = 0; v < 8; v++) flip[v] = gold(3'(v)) & 4'b0001;
        sweep("bit0", -1);
        check("bit0.err_abs", 32'(o_err), 32'd4);
        check("bit0.fvec_abs", 32'(o_fvec), 32'd2);
        check("bit0.fmask_abs", 32'(o_fmask), 32'd1);

        sel = 1;
        for (int v = 0; v < 16; v++) flip[v] = 4'hF;
        sweep("sat", -1);
        check("sat.err_abs", 32'(o_err), 32'd15);
        check("sat.fvec_abs", 32'(o_fvec), 32'd0);
        check("sat.fmask_abs", 32'(o_fmask), 32'hF);

        sel = 0;
        set_flips_random();
        flip[1] = 4'h6;
        sweep("pulse", 6);
        for (int v = 0; v < 16; v++) flip[v] = 4'h0;
        sweep("restart", -1);

        for (int v = 0; v < 16; v++) flip[v] = 4'hF;
        reset_mid_sweep();
        for (int v = 0; v < 16; v++) flip[v] = 4'h0;
        sweep("post_rst", -1);

        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("rst_start.state", 32'(o_state), 32'(truth_table_pkg::IDLE));
        check("rst_start.busy", 32'(o_busy), 32'd0);
        rst   = 1'b0;
        start = 1'b0;

        sel = 2;
        sweep("wide_clean", -1);
        for (int r = 0; r < 3; r++) begin
            for (int s = 0; s < 3; s++) begin
                sel = s;
                set_flips_random();
                sweep($sformatf("rand%0d_%0d", r, s), -1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
